// File: rtl/obstacle_if.sv
// obstacle_if: beam position and game control into the obstacle engine,
// pixel bit and obstacle geometry out. OBSTACLE_FLYING_EN adds o_obs_fly.
interface obstacle_if #(
  parameter int CONV = 0
);
  logic [9-CONV:0] i_hpos;
  logic [9-CONV:0] i_vpos;
  logic            i_frame_tick;
  logic            i_game_active;
  logic            i_game_restart;
  logic            o_color_obstacle;
  logic [10:0]     o_obs0_x;
  logic [10:0]     o_obs1_x;
  logic [1:0]      o_obs_valid;
  logic [5:0]      o_obs_h0;
  logic [5:0]      o_obs_h1;
  logic [2:0]      o_speed;
`ifdef OBSTACLE_FLYING_EN
  logic [1:0]      o_obs_fly;
`endif

  modport master (
    output i_hpos, i_vpos, i_frame_tick, i_game_active, i_game_restart,
    input  o_color_obstacle, o_obs0_x, o_obs1_x, o_obs_valid, o_obs_h0, o_obs_h1, o_speed
`ifdef OBSTACLE_FLYING_EN
    , input o_obs_fly
`endif
  );

  modport slave (
    input  i_hpos, i_vpos, i_frame_tick, i_game_active, i_game_restart,
    output o_color_obstacle, o_obs0_x, o_obs1_x, o_obs_valid, o_obs_h0, o_obs_h1, o_speed
`ifdef OBSTACLE_FLYING_EN
    , output o_obs_fly
`endif
  );
endinterface

// File: rtl/obstacle_engine.sv
// obstacle_engine: two scrolling obstacle slots, LFSR-timed spawning, per-frame
// scroll with speed ramp, and a registered per-pixel obstacle bit.
// Optional macro OBSTACLE_FLYING_EN: per-slot fly flag raising the obstacle 48 rows.

// Per-slot hit test against the current beam position.
module obstacle_slot_hit #(
  parameter int GROUND_Y = 400,
  parameter int OBS_W    = 16
) (
  input  logic        vld,
  input  logic [10:0] x,
  input  logic [5:0]  h,
  input  logic        fly,
  input  logic [11:0] px,
  input  logic [11:0] py,
  output logic        hit
);
  int xs, bot, top;

  // Signed column compare keeps slots partly past the left edge visible
  always_comb begin
    xs  = int'($signed(x));
    bot = fly ? GROUND_Y - 48 : GROUND_Y;
    top = bot - int'(h);
    hit = vld && (xs <= int'(px)) && (int'(px) < xs + OBS_W) &&
          (top <= int'(py)) && (int'(py) < bot);
  end
endmodule

module obstacle_engine #(
  parameter int CONV      = 0,
  parameter int GROUND_Y  = 400,
  parameter int OBS_W     = 16,
  parameter int OBS_H     = 32,
  parameter int MIN_GAP   = 160,
  parameter int SPEED_MAX = 7
) (
  input logic       clk,
  input logic       reset,
  obstacle_if.slave bus
);
  localparam int          NUM_SLOTS = 2;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [NUM_SLOTS-1:0][10:0] x, x_nxt;
  logic [NUM_SLOTS-1:0][5:0]  h, h_nxt;
  logic [NUM_SLOTS-1:0]       vld, vld_nxt, hit, fly_eff;
  logic [8:0]                 gap, gap_nxt, frame_cnt;
  logic [2:0]                 speed, speed_nxt;
  logic [15:0]                lfsr;
  logic [11:0]                px, py;
  logic                       spawn_due, spawned, upd, clr, color;

`ifdef OBSTACLE_FLYING_EN
  logic [NUM_SLOTS-1:0] fly, fly_nxt;
  assign fly_eff       = fly;
  assign bus.o_obs_fly = fly;
`else
  assign fly_eff = '0;
`endif

  assign upd = bus.i_frame_tick && bus.i_game_active;
  assign clr = reset || bus.i_game_restart;
  assign px  = 12'(bus.i_hpos) << CONV;
  assign py  = 12'(bus.i_vpos) << CONV;

  obstacle_slot_hit #(.GROUND_Y(GROUND_Y), .OBS_W(OBS_W)) u_hit [NUM_SLOTS-1:0] (
    .vld(vld), .x(x), .h(h), .fly(fly_eff), .px(px), .py(py), .hit(hit)
  );

  // Free-running LFSR; restart deliberately leaves it alone
  always_ff @(posedge clk)
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Frame update: move, expire, gap countdown, spawn into lowest free slot, speed ramp
  always_comb begin
    x_nxt     = x;
    h_nxt     = h;
    vld_nxt   = vld;
    speed_nxt = speed;
    spawned   = 1'b0;
`ifdef OBSTACLE_FLYING_EN
    fly_nxt   = fly;
`endif
    spawn_due = (gap <= 9'(speed));
    for (int i = 0; i < NUM_SLOTS; i++)
      if (vld[i]) begin
        x_nxt[i] = x[i] - 11'(speed);
        if (int'($signed(x_nxt[i])) + OBS_W <= 0) vld_nxt[i] = 1'b0;
      end
    gap_nxt = spawn_due ? 9'd0 : gap - 9'(speed);
    for (int i = 0; i < NUM_SLOTS; i++)
      if (spawn_due && !spawned && !vld_nxt[i]) begin
        vld_nxt[i] = 1'b1;
        x_nxt[i]   = 11'd640;
        h_nxt[i]   = lfsr[0] ? 6'(OBS_H) : 6'(OBS_H / 2);
`ifdef OBSTACLE_FLYING_EN
        fly_nxt[i] = lfsr[8];
`endif
        gap_nxt    = 9'(MIN_GAP) + {2'b00, lfsr[7:1]};
        spawned    = 1'b1;
      end
    if (frame_cnt == '1 && speed < 3'(SPEED_MAX)) speed_nxt = speed + 3'd1;
  end

  // Slot/gap/speed state; restart wins over a coincident frame tick
  always_ff @(posedge clk)
    if (clr) begin
      x         <= '0;
      h         <= '0;
      vld       <= '0;
      gap       <= 9'(MIN_GAP);
      speed     <= 3'd2;
      frame_cnt <= '0;
`ifdef OBSTACLE_FLYING_EN
      fly       <= '0;
`endif
    end else if (upd) begin
      x         <= x_nxt;
      h         <= h_nxt;
      vld       <= vld_nxt;
      gap       <= gap_nxt;
      speed     <= speed_nxt;
      frame_cnt <= frame_cnt + 9'd1;
`ifdef OBSTACLE_FLYING_EN
      fly       <= fly_nxt;
`endif
    end

  // Registered pixel bit, one clock behind the beam position
  always_ff @(posedge clk)
    if (clr) color <= 1'b0;
    else     color <= |hit;

  assign bus.o_color_obstacle = color;
  assign bus.o_obs0_x         = x[0];
  assign bus.o_obs1_x         = x[1];
  assign bus.o_obs_valid      = vld;
  assign bus.o_obs_h0         = h[0];
  assign bus.o_obs_h1         = h[1];
  assign bus.o_speed          = speed;
endmodule

// File: tb/tb_obstacle_engine.sv
// tb_obstacle_engine: directed scenarios plus randomized traffic checked
// against a behavioural model of the obstacle rules.
`timescale 1ns/1ps
module tb_obstacle_engine;
  localparam int GROUND_Y = 400, OBS_W = 16, OBS_H = 32, MIN_GAP = 160, SPEED_MAX = 7;

  logic clk = 1'b0;
  logic reset;
  obstacle_if #(.CONV(0)) bus ();

  obstacle_engine #(
    .CONV(0), .GROUND_Y(GROUND_Y), .OBS_W(OBS_W), .OBS_H(OBS_H),
    .MIN_GAP(MIN_GAP), .SPEED_MAX(SPEED_MAX)
  ) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Behavioural model state
  int          m_x[2], m_h[2], m_gap, m_speed, m_fc;
  bit          m_v[2], m_fly[2], m_color;
  logic [15:0] m_lfsr;

  logic [39:0] obs_vec;
  assign obs_vec = {bus.o_obs_valid, bus.o_obs0_x, bus.o_obs1_x, bus.o_obs_h0,
                    bus.o_obs_h1, bus.o_speed, bus.o_color_obstacle};

  function automatic logic [39:0] exp_vec();
    return {m_v[1], m_v[0], 11'(m_x[0]), 11'(m_x[1]), 6'(m_h[0]), 6'(m_h[1]),
            3'(m_speed), m_color};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) begin
      m_x[i] = 0; m_h[i] = 0; m_v[i] = 0; m_fly[i] = 0;
    end
    m_gap = MIN_GAP; m_speed = 2; m_fc = 0; m_color = 0;
  endfunction

  function automatic int bottom(int i);
    return GROUND_Y - (m_fly[i] ? 48 : 0);
  endfunction

  function automatic bit model_hit(int px, int py);
    bit r = 0;
    for (int i = 0; i < 2; i++)
      if (m_v[i] && px >= m_x[i] && px < m_x[i] + OBS_W &&
          py >= bottom(i) - m_h[i] && py < bottom(i)) r = 1;
    return r;
  endfunction

  function automatic void frame_update();
    bit due;
    int free_slot;
    due = (m_gap <= m_speed);
    free_slot = -1;
    for (int i = 0; i < 2; i++)
      if (m_v[i]) begin
        m_x[i] -= m_speed;
        if (m_x[i] + OBS_W <= 0) m_v[i] = 0;
      end
    m_gap = (m_gap > m_speed) ? m_gap - m_speed : 0;
    for (int i = 1; i >= 0; i--) if (!m_v[i]) free_slot = i;
    if (due && free_slot >= 0) begin
      m_v[free_slot] = 1;
      m_x[free_slot] = 640;
      m_h[free_slot] = m_lfsr[0] ? OBS_H : OBS_H / 2;
`ifdef OBSTACLE_FLYING_EN
      m_fly[free_slot] = m_lfsr[8];
`endif
      m_gap = MIN_GAP + int'(m_lfsr[7:1]);
    end
    m_fc++;
    if (m_fc == 512) begin
      m_fc = 0;
      if (m_speed < SPEED_MAX) m_speed++;
    end
  endfunction

  // One clock: drive inputs, advance model at the edge, return on the falling edge
  task automatic step(input bit tick, input bit act, input bit rst_g, input int hp, input int vp);
    bus.i_frame_tick = tick; bus.i_game_active = act; bus.i_game_restart = rst_g;
    bus.i_hpos = 10'(hp); bus.i_vpos = 10'(vp);
    @(posedge clk);
    if (rst_g) model_clear();
    else begin
      m_color = model_hit(hp, vp);
      if (tick && act) frame_update();
    end
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    @(negedge clk);
    bus.i_frame_tick = 1'b0; bus.i_game_restart = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.i_frame_tick = 0; bus.i_game_active = 0; bus.i_game_restart = 0;
    bus.i_hpos = '0; bus.i_vpos = '0;
    repeat (3) @(posedge clk);
    model_clear(); m_lfsr = 16'hACE1;
    @(negedge clk); reset = 1'b0;
    checks++; if (bus.o_obs_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b want 00", bus.o_obs_valid); end
    checks++; if (bus.o_obs0_x !== 11'd0) begin errors++; $display("FAIL reset_x0: got %0d want 0", bus.o_obs0_x); end
    checks++; if (bus.o_obs1_x !== 11'd0) begin errors++; $display("FAIL reset_x1: got %0d want 0", bus.o_obs1_x); end
    checks++; if (bus.o_obs_h0 !== 6'd0 || bus.o_obs_h1 !== 6'd0) begin errors++; $display("FAIL reset_h: got %0d/%0d want 0/0", bus.o_obs_h0, bus.o_obs_h1); end
    checks++; if (bus.o_speed !== 3'd2) begin errors++; $display("FAIL reset_speed: got %0d want 2", bus.o_speed); end
    checks++; if (bus.o_color_obstacle !== 1'b0) begin errors++; $display("FAIL reset_color: got %b want 0", bus.o_color_obstacle); end
  endtask

  task automatic test_gap_spawn();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, $urandom_range(0, 639), $urandom_range(0, 479));
      checks++; if (bus.o_obs_valid !== 2'b00 || bus.o_color_obstacle !== 1'b0) begin errors++; $display("FAIL early_tick: valid %b color %b want 00 0", bus.o_obs_valid, bus.o_color_obstacle); end
    end
    repeat (76) step(1, 1, 0, 0, 0);
    checks++; if (bus.o_obs_valid !== 2'b00) begin errors++; $display("FAIL pre_spawn: got %b want 00", bus.o_obs_valid); end
    step(1, 1, 0, 0, 0);
    checks++; if (bus.o_obs_valid !== 2'b01) begin errors++; $display("FAIL spawn_valid: got %b want 01", bus.o_obs_valid); end
    checks++; if (bus.o_obs0_x !== 11'd640) begin errors++; $display("FAIL spawn_x: got %0d want 640", bus.o_obs0_x); end
    checks++; if (bus.o_obs_h0 !== 6'(m_h[0]) || (m_h[0] != 32 && m_h[0] != 16)) begin errors++; $display("FAIL spawn_h: got %0d want %0d", bus.o_obs_h0, m_h[0]); end
    repeat (10) step(1, 1, 0, 0, 0);
    checks++; if (bus.o_obs0_x !== 11'd620) begin errors++; $display("FAIL scroll_x: got %0d want 620", bus.o_obs0_x); end
    checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL scroll_state: got %h want %h", obs_vec, exp_vec()); end
  endtask

  task automatic test_pixel();
    int xo, b, hh;
    int hp[6], vp[6];
    bit ex[6];
    xo = m_x[0]; b = bottom(0); hh = m_h[0];
    hp = '{xo, xo + 16, xo + 15, xo, xo - 1, xo};
    vp = '{b - 1, b - 1, b - hh, b, b - 1, b - hh - 1};
    ex = '{1, 0, 1, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, hp[i], vp[i]);
      checks++; if (bus.o_color_obstacle !== ex[i]) begin errors++; $display("FAIL pixel_%0d: got %b want %b (h=%0d v=%0d)", i, bus.o_color_obstacle, ex[i], hp[i], vp[i]); end
    end
  endtask

  task automatic test_expire();
    bit done = 0, probed = 0, at_m14;
    for (int i = 0; i < 600 && !done; i++) begin
      if (!probed && m_v[0] && m_x[0] < 0 && m_x[0] > -OBS_W) begin
        step(0, 1, 0, 0, bottom(0) - 1);
        probed = 1;
        checks++; if (bus.o_color_obstacle !== 1'b1) begin errors++; $display("FAIL edge_draw: got %b want 1 (x=%0d)", bus.o_color_obstacle, m_x[0]); end
      end
      at_m14 = m_v[0] && m_x[0] == -14 && m_speed == 2;
      step(1, 1, 0, 0, bottom(0) - 1);
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL expire_state: got %h want %h", obs_vec, exp_vec()); end
      if (at_m14) begin
        done = 1;
        checks++; if (bus.o_obs_valid[0] && bus.o_obs0_x !== 11'd640) begin errors++; $display("FAIL expire_slot0: valid %b x %0d want invalid or respawned", bus.o_obs_valid, bus.o_obs0_x); end
      end
    end
    checks++; if (!done || !probed) begin errors++; $display("FAIL expire_timeout: done %b probed %b want 1 1", done, probed); end
  endtask

  task automatic test_freeze();
    logic [39:0] snap;
    int s;
    snap = obs_vec;
    for (int i = 0; i < 20; i++) begin
      s = m_v[1] ? 1 : 0;
      step(1, 0, 0, (m_x[s] < 0) ? 0 : m_x[s] + (i % 16), bottom(s) - 1 - (i % 8));
      checks++; if (obs_vec[39:1] !== snap[39:1] || bus.o_color_obstacle !== m_color) begin errors++; $display("FAIL freeze_%0d: got %h want %h color %b", i, obs_vec, snap, m_color); end
    end
  endtask

  task automatic test_speed();
    step(0, 1, 1, 0, 0);
    checks++; if (bus.o_speed !== 3'd2 || bus.o_obs_valid !== 2'b00) begin errors++; $display("FAIL restart: speed %0d valid %b want 2 00", bus.o_speed, bus.o_obs_valid); end
    repeat (511) step(1, 1, 0, $urandom_range(0, 1023), $urandom_range(360, 400));
    checks++; if (bus.o_speed !== 3'd2) begin errors++; $display("FAIL speed_511: got %0d want 2", bus.o_speed); end
    step(1, 1, 0, 0, 0);
    checks++; if (bus.o_speed !== 3'd3) begin errors++; $display("FAIL speed_512: got %0d want 3", bus.o_speed); end
    for (int i = 0; i < 2048 + 600; i++) begin
      step(1, 1, 0, $urandom_range(0, 1023), $urandom_range(300, 420));
      if (i % 64 == 0) begin
        checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL ramp_state: got %h want %h", obs_vec, exp_vec()); end
      end
    end
    checks++; if (bus.o_speed !== 3'd7) begin errors++; $display("FAIL speed_sat: got %0d want 7", bus.o_speed); end
    step(1, 1, 1, 0, 0);
    checks++; if (bus.o_speed !== 3'd2 || bus.o_obs_valid !== 2'b00 || bus.o_obs0_x !== 11'd0 || bus.o_obs1_x !== 11'd0) begin errors++; $display("FAIL restart_tick: speed %0d valid %b x %0d/%0d want 2 00 0/0", bus.o_speed, bus.o_obs_valid, bus.o_obs0_x, bus.o_obs1_x); end
    repeat (79) step(1, 1, 0, 0, 0);
    checks++; if (bus.o_obs_valid !== 2'b00) begin errors++; $display("FAIL restart_gap79: got %b want 00", bus.o_obs_valid); end
    step(1, 1, 0, 0, 0);
    checks++; if (bus.o_obs_valid !== 2'b01) begin errors++; $display("FAIL restart_gap80: got %b want 01", bus.o_obs_valid); end
  endtask

  task automatic test_random();
    int s, hp, vp;
    for (int i = 0; i < 3000; i++) begin
      s = $urandom_range(0, 1);
      if (m_v[s] && $urandom_range(0, 1)) begin
        hp = m_x[s] + $urandom_range(0, 19) - 2;
        if (hp < 0) hp = 0;
        vp = bottom(s) - $urandom_range(0, 40) + 2;
      end else begin
        hp = $urandom_range(0, 1023); vp = $urandom_range(0, 1023);
      end
      step($urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 399) == 0, hp, vp);
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL random_%0d: got %h want %h", i, obs_vec, exp_vec()); end
`ifdef OBSTACLE_FLYING_EN
      checks++; if (bus.o_obs_fly !== {m_fly[1] & m_v[1] | m_fly[1], m_fly[0]}) begin errors++; $display("FAIL random_fly_%0d: got %b want %b%b", i, bus.o_obs_fly, m_fly[1], m_fly[0]); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_gap_spawn();
    test_pixel();
    test_expire();
    test_freeze();
    test_speed();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
